// File: rtl/score_pkg.sv
// Shared constants, seven-segment table and converter state type for the score display.
package score_pkg;
  localparam int unsigned DIGITS  = 4;
  localparam int unsigned MAX_VAL = 9999;
  localparam int unsigned SHIFT_W = 14;
  localparam int unsigned BCD_W   = 4 * DIGITS;
  localparam int unsigned CNT_W   = $clog2(SHIFT_W + 1);

  // Active-low segments, bit6..bit0 = g..a
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_TABLE [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;
endpackage

// File: rtl/score_bcd_display_seg7_decoder.sv
// One BCD nibble to active-low seven-segment code; non-decimal nibbles show blank.
module seg7_decoder
  import score_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    if (!blank && (nibble < 4'd10)) seg_c = SEG_TABLE[nibble];
  end

endmodule

// File: rtl/score_bcd_display.sv
// Clamps the live score, converts it (or the session best) to BCD with a
// serial double-dabble engine and drives active-low seven-segment digits.
module score_bcd_display
  import score_pkg::*;
#(
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic [31:0]          score_in,
  input  logic                 game_over,
  input  logic                 show_best,
  output logic [BCD_W-1:0]     bcd_out,
  output logic [6:0]           hex0,
  output logic [6:0]           hex1,
  output logic [6:0]           hex2,
  output logic [6:0]           hex3,
  output logic [SHIFT_W-1:0]   best_score,
  output logic                 busy,
  output logic                 overflow
);

  localparam logic [6:0] HEX_HI_RST = BLANK_LZ ? SEG_BLANK : SEG_TABLE[0];

  conv_state_t        state, state_nxt;
  logic [SHIFT_W-1:0] clamp, sel, last_conv, cap_val, bin_sr;
  logic [BCD_W-1:0]   bcd_sr, bcd_adj;
  logic [CNT_W-1:0]   cnt;
  logic               load_c, shift_c, done_c;
  logic               game_over_d;
  logic [DIGITS-1:0]  blank_c;
  logic [6:0]         seg_c [DIGITS];

  assign clamp = (score_in > 32'(MAX_VAL)) ? SHIFT_W'(MAX_VAL) : score_in[SHIFT_W-1:0];
  assign sel   = show_best ? best_score : clamp;

  // Double-dabble correction: any nibble >= 5 gets +3 before the shift
  always_comb begin
    bcd_adj = bcd_sr;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_sr[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (sel != last_conv) state_nxt = SHIFT;
      SHIFT:   if (cnt == CNT_W'(SHIFT_W - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_c  = 1'b0;
    shift_c = 1'b0;
    done_c  = 1'b0;
    unique case (state)
      IDLE:    load_c  = (sel != last_conv);
      SHIFT:   shift_c = 1'b1;
      DONE:    done_c  = 1'b1;
      default: ;
    endcase
  end

  // Digit i>0 blanks when it and every higher digit are zero
  assign blank_c[0] = 1'b0;
  for (genvar i = 1; i < int'(DIGITS); i++) begin : g_blank
    assign blank_c[i] = BLANK_LZ && (bcd_sr[BCD_W-1:4*i] == '0);
  end

  for (genvar i = 0; i < int'(DIGITS); i++) begin : g_seg
    seg7_decoder u_seg (
      .nibble (bcd_sr[4*i +: 4]),
      .blank  (blank_c[i]),
      .seg_c  (seg_c[i])
    );
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      bcd_out     <= '0;
      hex0        <= SEG_TABLE[0];
      hex1        <= HEX_HI_RST;
      hex2        <= HEX_HI_RST;
      hex3        <= HEX_HI_RST;
      best_score  <= '0;
      busy        <= 1'b0;
      overflow    <= 1'b0;
      game_over_d <= 1'b0;
      last_conv   <= '0;
      cap_val     <= '0;
      bin_sr      <= '0;
      bcd_sr      <= '0;
      cnt         <= '0;
    end else begin
      busy        <= (state_nxt != IDLE);
      overflow    <= (score_in > 32'(MAX_VAL));
      game_over_d <= game_over;
      // Best score captured only on the rising edge of game_over
      if (game_over && !game_over_d && (clamp > best_score)) best_score <= clamp;

      if (load_c) begin
        bin_sr  <= sel;
        bcd_sr  <= '0;
        cnt     <= '0;
        cap_val <= sel;
      end
      if (shift_c) begin
        {bcd_sr, bin_sr} <= {bcd_adj[BCD_W-2:0], bin_sr, 1'b0};
        cnt              <= cnt + CNT_W'(1);
      end
      if (done_c) begin
        bcd_out   <= bcd_sr;
        last_conv <= cap_val;
        hex0      <= seg_c[0];
        hex1      <= seg_c[1];
        hex2      <= seg_c[2];
        hex3      <= seg_c[3];
      end
    end
  end

endmodule

// File: tb/tb_score_bcd_display.sv
// Directed plus randomized checks of score_bcd_display against an arithmetic decimal model.
module tb_score_bcd_display;

  logic        clk = 1'b0;
  logic        resetN;
  logic [31:0] score_in;
  logic        game_over;
  logic        show_best;
  logic [15:0] bcd_out;
  logic [6:0]  hex0, hex1, hex2, hex3;
  logic [13:0] best_score;
  logic        busy;
  logic        overflow;

  int vectors     = 0;
  int miscompares = 0;
  int mdl_best    = 0;
  bit mdl_go_d    = 1'b0;

  localparam logic [6:0] SEGS [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  always #5 clk = ~clk;

  score_bcd_display dut (
    .clk        (clk),
    .resetN     (resetN),
    .score_in   (score_in),
    .game_over  (game_over),
    .show_best  (show_best),
    .bcd_out    (bcd_out),
    .hex0       (hex0),
    .hex1       (hex1),
    .hex2       (hex2),
    .hex3       (hex3),
    .best_score (best_score),
    .busy       (busy),
    .overflow   (overflow)
  );

  function automatic int p10(input int i);
    int r = 1;
    for (int j = 0; j < i; j++) r = r * 10;
    return r;
  endfunction

  function automatic logic [15:0] exp_bcd(input int v);
    logic [15:0] r = '0;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'((v / p10(i)) % 10);
    return r;
  endfunction

  function automatic logic [6:0] exp_seg(input int v, input int i);
    if (i > 0 && v < p10(i)) return 7'h7F;
    return SEGS[(v / p10(i)) % 10];
  endfunction

  function automatic int clampf(input logic [31:0] s);
    return (s > 32'd9999) ? 9999 : int'(s);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_display(input string tag, input int v);
    check({tag, "/bcd"},  32'(bcd_out), 32'(exp_bcd(v)));
    check({tag, "/hex0"}, 32'(hex0), 32'(exp_seg(v, 0)));
    check({tag, "/hex1"}, 32'(hex1), 32'(exp_seg(v, 1)));
    check({tag, "/hex2"}, 32'(hex2), 32'(exp_seg(v, 2)));
    check({tag, "/hex3"}, 32'(hex3), 32'(exp_seg(v, 3)));
  endtask

  // Run until busy has been low on two consecutive edges (covers back-to-back restarts)
  task automatic drain(input string tag);
    int quiet = 0;
    int n = 0;
    while (quiet < 2 && n < 100) begin
      step();
      n++;
      if (!busy) quiet++;
      else quiet = 0;
    end
    check({tag, "/settled"}, 32'(quiet), 32'd2);
  endtask

  // Inputs already applied; the next edge must start a conversion of v
  task automatic convert(input string tag, input int v, input int prev);
    int n = 0;
    step();
    check({tag, "/busy_start"}, 32'(busy), 32'd1);
    while (busy && n < 40) begin
      step();
      n++;
      if (n == 14) check({tag, "/bcd_hold"}, 32'(bcd_out), 32'(exp_bcd(prev)));
    end
    check({tag, "/latency"}, 32'(n), 32'd15);
    check_display(tag, v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m, s, r;
    bit sb, go;

    resetN = 1'b0; score_in = '0; game_over = 1'b0; show_best = 1'b0;
    step(); step();
    resetN = 1'b1;
    step();
    check_display("reset", 0);
    check("reset/busy", 32'(busy), 0);
    check("reset/best", 32'(best_score), 0);
    check("reset/ovf", 32'(overflow), 0);
    step(); step(); step();
    check("reset/no_conv", 32'(busy), 0);

    score_in = 32'd1234;
    convert("t1234", 1234, 0);

    score_in = 32'd20000;
    convert("tclamp", 9999, 1234);
    check("tclamp/ovf", 32'(overflow), 1);
    score_in = 32'd5;
    convert("t5", 5, 9999);
    check("t5/ovf", 32'(overflow), 0);

    score_in = 32'd57; game_over = 1'b1; step();
    check("best57", 32'(best_score), 57);
    game_over = 1'b0; score_in = 32'd30; step();
    game_over = 1'b1; step();
    check("best_keep", 32'(best_score), 57);
    game_over = 1'b0; score_in = 32'd100; step();
    game_over = 1'b1; step();
    check("best100", 32'(best_score), 100);
    score_in = 32'd500; step(); step(); step();
    check("best_held", 32'(best_score), 100);
    game_over = 1'b0;
    drain("t500");
    check_display("t500", 500);

    score_in = 32'd777;
    step();
    check("abort/busy", 32'(busy), 1);
    for (int i = 0; i < 7; i++) step();
    #2 resetN = 1'b0;
    #1;
    check_display("abort", 0);
    check("abort/busy0", 32'(busy), 0);
    check("abort/best", 32'(best_score), 0);
    check("abort/ovf", 32'(overflow), 0);
    score_in = 32'd42;
    step();
    resetN = 1'b1;
    convert("t42", 42, 0);

    score_in = 32'd57; game_over = 1'b1; step();
    game_over = 1'b0;
    check("best57b", 32'(best_score), 57);
    drain("t57");
    score_in = 32'd200; show_best = 1'b1;
    drain("show_best");
    check_display("show_best", 57);
    show_best = 1'b0;
    drain("show_live");
    check_display("show_live", 200);

    // Change of input in the middle of a conversion
    score_in = 32'd5;
    step();
    check("mid/busy", 32'(busy), 1);
    n = 0;
    for (int i = 0; i < 3; i++) begin step(); n++; end
    score_in = 32'd6;
    while (busy && n < 40) begin step(); n++; end
    check("mid/lat5", 32'(n), 15);
    check_display("mid5", 5);
    m = 0;
    while (bcd_out !== exp_bcd(6) && m < 40) begin step(); m++; end
    check("mid/lat6", 32'(m), 16);
    check_display("mid6", 6);

    mdl_best = 57;
    mdl_go_d = 1'b0;
    for (int it = 0; it < 25; it++) begin
      r = int'($urandom_range(0, 3));
      if (r == 0)      s = int'($urandom);
      else if (r == 1) s = int'($urandom_range(9990, 10010));
      else             s = int'($urandom_range(0, 9999));
      sb = 1'($urandom_range(0, 1));
      go = 1'($urandom_range(0, 1));
      score_in = 32'(s); show_best = sb; game_over = go;
      step();
      if (go && !mdl_go_d && clampf(32'(s)) > mdl_best) mdl_best = clampf(32'(s));
      mdl_go_d = go;
      drain("rand");
      check("rand/best", 32'(best_score), 32'(mdl_best));
      check("rand/ovf", 32'(overflow), (32'(s) > 32'd9999) ? 32'd1 : 32'd0);
      check_display("rand", sb ? mdl_best : clampf(32'(s)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
